fp_issue_wb: RTL and testbench

//  Back end of the FP decode interface: accepts one decoded FP instruction (op, formats, rm, rd,

---
 rtl/fp_issue_wb.sv | 236 +++++++++++++++++++++++
 tb/tb_fp_issue_wb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_wb.sv
`timescale 1ns/1ps
// FP issue/writeback back end: takes one decoded FP instruction, resolves its rounding mode,
// hands it to fpnew and writes the result (NaN-boxed where needed) to the FP or integer regfile.
module fp_issue_wb #(
  parameter int unsigned FLEN = 64,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a valid side holds its payload unchanged until that edge and never waits on ready.
  input  logic            dec_valid_i,
  output logic            dec_ready_o,
  input  logic [3:0]      dec_op_i,
  input  logic            dec_op_mod_i,
  input  logic [2:0]      dec_rm_i,
  input  logic            dec_rm_dynamic_i,
  input  logic [2:0]      dec_src_fmt_i,
  input  logic [2:0]      dec_dst_fmt_i,
  input  logic [4:0]      dec_rd_i,
  input  logic            dec_fp_we_i,
  input  logic            dec_mv_i,
  input  logic [FLEN-1:0] dec_opa_i,
  input  logic [FLEN-1:0] dec_opb_i,
  input  logic [FLEN-1:0] dec_opc_i,
  input  logic [2:0]      frm_i,
  input  logic            flush_i,
  output logic            fpu_in_valid_o,
  input  logic            fpu_in_ready_i,
  output logic [3:0]      fpu_op_o,
  output logic            fpu_op_mod_o,
  output logic [2:0]      fpu_rm_o,
  output logic [2:0]      fpu_src_fmt_o,
  output logic [2:0]      fpu_dst_fmt_o,
  output logic [FLEN-1:0] fpu_opa_o,
  output logic [FLEN-1:0] fpu_opb_o,
  output logic [FLEN-1:0] fpu_opc_o,
  input  logic            fpu_out_valid_i,
  output logic            fpu_out_ready_o,
  input  logic [FLEN-1:0] fpu_result_i,
  input  logic [4:0]      fpu_status_i,
  output logic            fp_wb_we_o,
  output logic [4:0]      fp_wb_addr_o,
  output logic [FLEN-1:0] fp_wb_data_o,
  output logic            int_wb_we_o,
  output logic [4:0]      int_wb_addr_o,
  output logic [XLEN-1:0] int_wb_data_o,
  output logic            fflags_we_o,
  output logic [4:0]      fflags_o,
  output logic            illegal_rm_o,
  output logic            busy_o,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam logic [2:0] FMT_FP32 = 3'd0;

  state_e            state_q, state_d;
  logic              killed_q, killed_d;
  logic [3:0]        op_q, op_d;
  logic              op_mod_q, op_mod_d;
  logic [2:0]        rm_q, rm_d;
  logic [2:0]        src_fmt_q, src_fmt_d;
  logic [2:0]        dst_fmt_q, dst_fmt_d;
  logic [4:0]        rd_q, rd_d;
  logic              fp_we_q, fp_we_d;
  logic              mv_q, mv_d;
  logic [FLEN-1:0]   opa_q, opa_d;
  logic [FLEN-1:0]   opb_q, opb_d;
  logic [FLEN-1:0]   opc_q, opc_d;
  logic [FLEN-1:0]   res_q, res_d;
  logic [4:0]        status_q, status_d;

  logic [2:0]        rm_sel;
  logic              rm_bad;
  logic              wb_ok;
  logic [FLEN-1:0]   fp_data;
  logic [XLEN-1:0]   int_data;

  function automatic logic [FLEN-1:0] nan_box(input logic [31:0] v);
    logic [FLEN-1:0] r;
    r       = '1;
    r[31:0] = v;
    return r;
  endfunction

  // frm values 5..7 are reserved encodings; only a dynamic rm can select them.
  assign rm_sel = dec_rm_dynamic_i ? frm_i : dec_rm_i;
  assign rm_bad = dec_rm_dynamic_i && (frm_i >= 3'd5);

  always_comb begin
    state_d   = state_q;
    killed_d  = killed_q;
    op_d      = op_q;
    op_mod_d  = op_mod_q;
    rm_d      = rm_q;
    src_fmt_d = src_fmt_q;
    dst_fmt_d = dst_fmt_q;
    rd_d      = rd_q;
    fp_we_d   = fp_we_q;
    mv_d      = mv_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    opc_d     = opc_q;
    res_d     = res_q;
    status_d  = status_q;
    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        if (dec_valid_i) begin
          op_d      = dec_op_i;
          op_mod_d  = dec_op_mod_i;
          rm_d      = rm_sel;
          src_fmt_d = dec_src_fmt_i;
          dst_fmt_d = dec_dst_fmt_i;
          rd_d      = dec_rd_i;
          fp_we_d   = dec_fp_we_i;
          mv_d      = dec_mv_i;
          opa_d     = dec_opa_i;
          opb_d     = dec_opb_i;
          opc_d     = dec_opc_i;
          status_d  = '0;
          if (rm_bad)        state_d = S_ERR;
          else if (dec_mv_i) state_d = S_WB;
          else               state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Once fpnew has taken the op its result must still be drained, so a flush
        // coinciding with the handshake only marks the op as killed.
        if (fpu_in_ready_i) begin
          state_d  = S_WAIT;
          killed_d = flush_i;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush_i) killed_d = 1'b1;
        if (fpu_out_valid_i) begin
          res_d    = fpu_result_i;
          status_d = fpu_status_i;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        killed_d = 1'b0;
        state_d  = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fp_data  = (mv_q || dst_fmt_q == FMT_FP32) ? nan_box(mv_q ? opa_q[31:0] : res_q[31:0]) : res_q;
    int_data = mv_q ? XLEN'($signed(opa_q[31:0])) : XLEN'(res_q);
    wb_ok    = (state_q == S_WB) && !killed_q && !flush_i;

    dec_ready_o     = (state_q == S_IDLE);
    busy_o          = (state_q != S_IDLE);
    fpu_in_valid_o  = (state_q == S_ISSUE);
    fpu_out_ready_o = (state_q == S_WAIT);
    illegal_rm_o    = (state_q == S_ERR);
    dbg_state_o     = state_q;

    fp_wb_we_o    = wb_ok && fp_we_q;
    int_wb_we_o   = wb_ok && !fp_we_q;
    fflags_we_o   = wb_ok && !mv_q;
    fp_wb_addr_o  = '0;
    int_wb_addr_o = '0;
    fp_wb_data_o  = '0;
    int_wb_data_o = '0;
    fflags_o      = '0;
    if (state_q == S_WB) begin
      fp_wb_addr_o  = rd_q;
      int_wb_addr_o = rd_q;
      fp_wb_data_o  = fp_data;
      int_wb_data_o = int_data;
      if (!mv_q) fflags_o = status_q;
    end

    fpu_op_o      = op_q;
    fpu_op_mod_o  = op_mod_q;
    fpu_rm_o      = rm_q;
    fpu_src_fmt_o = src_fmt_q;
    fpu_dst_fmt_o = dst_fmt_q;
    fpu_opa_o     = opa_q;
    fpu_opb_o     = opb_q;
    fpu_opc_o     = opc_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      killed_q  <= 1'b0;
      op_q      <= '0;
      op_mod_q  <= 1'b0;
      rm_q      <= '0;
      src_fmt_q <= '0;
      dst_fmt_q <= '0;
      rd_q      <= '0;
      fp_we_q   <= 1'b0;
      mv_q      <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      opc_q     <= '0;
      res_q     <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      killed_q  <= killed_d;
      op_q      <= op_d;
      op_mod_q  <= op_mod_d;
      rm_q      <= rm_d;
      src_fmt_q <= src_fmt_d;
      dst_fmt_q <= dst_fmt_d;
      rd_q      <= rd_d;
      fp_we_q   <= fp_we_d;
      mv_q      <= mv_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opc_q     <= opc_d;
      res_q     <= res_d;
      status_q  <= status_d;
    end
  end

endmodule

// File: tb/tb_fp_issue_wb.sv
`timescale 1ns/1ps
// Bench for fp_issue_wb: directed vector table, randomized vectors against a reference model,
// and hand-written reset corner sequences; fpnew is emulated with programmable delays.
module tb_fp_issue_wb;
  localparam int FLEN = 64;
  localparam int XLEN = 32;

  logic clk_i, rst_i;
  logic dec_valid_i, dec_ready_o, dec_op_mod_i, dec_rm_dynamic_i, dec_fp_we_i, dec_mv_i;
  logic [3:0] dec_op_i;
  logic [2:0] dec_rm_i, dec_src_fmt_i, dec_dst_fmt_i, frm_i;
  logic [4:0] dec_rd_i;
  logic [FLEN-1:0] dec_opa_i, dec_opb_i, dec_opc_i;
  logic flush_i, fpu_in_valid_o, fpu_in_ready_i, fpu_op_mod_o;
  logic [3:0] fpu_op_o;
  logic [2:0] fpu_rm_o, fpu_src_fmt_o, fpu_dst_fmt_o;
  logic [FLEN-1:0] fpu_opa_o, fpu_opb_o, fpu_opc_o, fpu_result_i, fp_wb_data_o;
  logic fpu_out_valid_i, fpu_out_ready_o, fp_wb_we_o, int_wb_we_o, fflags_we_o;
  logic [4:0] fpu_status_i, fp_wb_addr_o, int_wb_addr_o, fflags_o;
  logic [XLEN-1:0] int_wb_data_o;
  logic illegal_rm_o, busy_o;
  logic [2:0] dbg_state_o;

  fp_issue_wb #(.FLEN(FLEN), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_op_i(dec_op_i),
    .dec_op_mod_i(dec_op_mod_i), .dec_rm_i(dec_rm_i), .dec_rm_dynamic_i(dec_rm_dynamic_i),
    .dec_src_fmt_i(dec_src_fmt_i), .dec_dst_fmt_i(dec_dst_fmt_i), .dec_rd_i(dec_rd_i),
    .dec_fp_we_i(dec_fp_we_i), .dec_mv_i(dec_mv_i), .dec_opa_i(dec_opa_i),
    .dec_opb_i(dec_opb_i), .dec_opc_i(dec_opc_i), .frm_i(frm_i), .flush_i(flush_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i), .fpu_op_o(fpu_op_o),
    .fpu_op_mod_o(fpu_op_mod_o), .fpu_rm_o(fpu_rm_o), .fpu_src_fmt_o(fpu_src_fmt_o),
    .fpu_dst_fmt_o(fpu_dst_fmt_o), .fpu_opa_o(fpu_opa_o), .fpu_opb_o(fpu_opb_o),
    .fpu_opc_o(fpu_opc_o), .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .fp_wb_we_o(fp_wb_we_o), .fp_wb_addr_o(fp_wb_addr_o), .fp_wb_data_o(fp_wb_data_o),
    .int_wb_we_o(int_wb_we_o), .int_wb_addr_o(int_wb_addr_o), .int_wb_data_o(int_wb_data_o),
    .fflags_we_o(fflags_we_o), .fflags_o(fflags_o), .illegal_rm_o(illegal_rm_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- records ----------------
  typedef struct {
    logic [3:0] op; logic op_mod; logic [2:0] rm; logic dyn; logic [2:0] frm;
    logic [2:0] src; logic [2:0] dst; logic [4:0] rd; logic fp_we; logic mv;
    logic [63:0] opa; logic [63:0] opb; logic [63:0] opc; logic [63:0] res; logic [4:0] status;
    int in_dly; int out_dly; int flush_mode;  // flush: 0 none,1 issue no-ready,2 at handshake,3 wait,4 wb
    logic [2:0] e_rm; int e_kind; logic [63:0] e_data; int e_fflags_we; logic [4:0] e_fflags;
    int e_illegal; int e_nvalid; int e_hs; int e_idle;
  } vec_t;

  vec_t tbl[$];
  logic [63:0] exp_q[$];
  int errors, checks;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.op = '0; v.op_mod = 1'b0; v.rm = '0; v.dyn = 1'b0; v.frm = '0; v.src = '0; v.dst = '0;
    v.rd = '0; v.fp_we = 1'b0; v.mv = 1'b0; v.opa = '0; v.opb = '0; v.opc = '0; v.res = '0;
    v.status = '0; v.in_dly = 0; v.out_dly = 0; v.flush_mode = 0; v.e_rm = '0; v.e_kind = 0;
    v.e_data = '0; v.e_fflags_we = 0; v.e_fflags = '0; v.e_illegal = 0; v.e_nvalid = 0;
    v.e_hs = 0; v.e_idle = 0;
    return v;
  endfunction

  function automatic logic [63:0] box32(input logic [31:0] x);
    return {32'hFFFF_FFFF, x};
  endfunction

  // Reference model: what the instruction should do, from the architectural rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int wb;
    bit bad, ok;
    r = v;
    bad = v.dyn && (v.frm >= 3'd5);
    r.e_rm = v.dyn ? v.frm : v.rm;
    r.e_illegal = bad ? 1 : 0;
    wb = -1;
    if (bad) begin
      r.e_nvalid = 0; r.e_hs = 0; r.e_idle = 2;
    end else if (v.mv) begin
      r.e_nvalid = 0; r.e_hs = 0; wb = 1; r.e_idle = 2;
    end else if (v.flush_mode == 1) begin
      r.e_nvalid = 1; r.e_hs = 0; r.e_idle = 2;
    end else begin
      r.e_nvalid = v.in_dly + 1; r.e_hs = 1;
      wb = 3 + v.in_dly + v.out_dly; r.e_idle = wb + 1;
    end
    ok = (wb > 0) && (v.flush_mode == 0);
    r.e_kind = !ok ? 0 : (v.fp_we ? 1 : 2);
    if (v.fp_we) r.e_data = v.mv ? box32(v.opa[31:0]) : ((v.dst == 3'd0) ? box32(v.res[31:0]) : v.res);
    else         r.e_data = v.mv ? {32'd0, v.opa[31:0]} : {32'd0, v.res[31:0]};
    r.e_fflags_we = (ok && !v.mv) ? 1 : 0;
    r.e_fflags = v.status;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_dec(input vec_t v);
    dec_op_i = v.op; dec_op_mod_i = v.op_mod; dec_rm_i = v.rm; dec_rm_dynamic_i = v.dyn;
    frm_i = v.frm; dec_src_fmt_i = v.src; dec_dst_fmt_i = v.dst; dec_rd_i = v.rd;
    dec_fp_we_i = v.fp_we; dec_mv_i = v.mv; dec_opa_i = v.opa; dec_opb_i = v.opb;
    dec_opc_i = v.opc; fpu_result_i = v.res; fpu_status_i = v.status;
  endtask

  task automatic idle_inputs();
    dec_valid_i = 1'b0; flush_i = 1'b0; fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n_valid = 0, n_hs = 0, n_ill = 0, n_ff = 0, idle_cyc = -1, in_cnt = 0, wait_cnt = 0;
    bit accepted = 0, delivered = 0, fld_bad = 0, flushed3 = 0;
    logic [63:0] d;
    exp_q.delete();
    if (v.e_kind != 0) exp_q.push_back(v.e_data);
    drive_dec(v);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_i);
      idle_inputs();
      dec_valid_i = (k == 0);
      if (fpu_in_valid_o) begin
        if (v.flush_mode == 1 && in_cnt == 0) flush_i = 1'b1;
        else if (in_cnt >= v.in_dly) begin
          fpu_in_ready_i = 1'b1;
          if (v.flush_mode == 2) flush_i = 1'b1;
        end
        in_cnt++;
      end
      if (fpu_out_ready_o) begin
        if (v.flush_mode == 3 && !flushed3) begin flush_i = 1'b1; flushed3 = 1; end
        if (accepted && !delivered && wait_cnt >= v.out_dly) begin
          fpu_out_valid_i = 1'b1; delivered = 1;
        end else wait_cnt++;
      end
      if (v.flush_mode == 4 && k == v.e_idle - 1) flush_i = 1'b1;
      #1;
      if (k == 0) check({tag, " dec_ready_at_accept"}, dec_ready_o, 1);
      if (fpu_in_valid_o) begin
        n_valid++;
        if ({fpu_op_o, fpu_op_mod_o, fpu_rm_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_opa_o, fpu_opb_o, fpu_opc_o}
            !== {v.op, v.op_mod, v.e_rm, v.src, v.dst, v.opa, v.opb, v.opc}) fld_bad = 1;
        if (fpu_in_ready_i) begin n_hs++; accepted = 1; end
      end
      if (k > 0 && dec_ready_o && idle_cyc < 0) idle_cyc = k;
      if (illegal_rm_o) n_ill++;
      if (fflags_we_o) begin
        n_ff++;
        check({tag, " fflags"}, fflags_o, v.e_fflags);
      end
      if (fp_wb_we_o || int_wb_we_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s unexpected_write: got fp_we=%0b int_we=%0b at cycle %0d expected none",
                   tag, fp_wb_we_o, int_wb_we_o, k);
        end else begin
          d = exp_q.pop_front();
          check({tag, " wb_data"}, fp_wb_we_o ? fp_wb_data_o : {32'd0, int_wb_data_o}, d);
          check({tag, " wb_port"}, {fp_wb_we_o, int_wb_we_o}, (v.e_kind == 1) ? 2'b10 : 2'b01);
          check({tag, " wb_addr"}, fp_wb_we_o ? fp_wb_addr_o : int_wb_addr_o, v.rd);
          check({tag, " wb_cycle"}, k, v.e_idle - 1);
        end
      end
      if (idle_cyc >= 0 && k >= v.e_idle + 1) break;
    end
    check({tag, " idle_cycle"}, idle_cyc, v.e_idle);
    check({tag, " illegal_pulses"}, n_ill, v.e_illegal);
    check({tag, " handshakes"}, n_hs, v.e_hs);
    check({tag, " valid_cycles"}, n_valid, v.e_nvalid);
    if (v.e_nvalid > 0) check({tag, " fields_stable"}, fld_bad, 0);
    check({tag, " fflags_we_count"}, n_ff, v.e_fflags_we);
    check({tag, " missing_write"}, exp_q.size(), 0);
    if (busy_o) begin
      rst_i = 1'b1; @(negedge clk_i); rst_i = 1'b0;
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_i); #1;
      check({tag, " quiet"}, {fp_wb_we_o, int_wb_we_o, fflags_we_o, illegal_rm_o, busy_o}, 5'b0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    errors = 0; checks = 0;
    rst_i = 1'b1;
    idle_inputs();
    drive_dec(blank());
    repeat (3) @(negedge clk_i);
    #1;
    check("reset ready_busy", {dec_ready_o, busy_o}, 2'b10);
    check("reset valids", {fpu_in_valid_o, fpu_out_ready_o, illegal_rm_o}, 3'b0);
    check("reset we", {fp_wb_we_o, int_wb_we_o, fflags_we_o}, 3'b0);
    check("reset fp_data", fp_wb_data_o, 0);
    check("reset int_data_addr_flags", {int_wb_data_o, fp_wb_addr_o, int_wb_addr_o, fflags_o}, 0);
    check("reset fpu_fields", {fpu_op_o, fpu_rm_o, fpu_opa_o}, 0);
    check("reset dbg_state", dbg_state_o, 0);
    rst_i = 1'b0;

    // FADD.S, single result must be NaN-boxed
    v = blank(); v.op = 4'd2; v.rd = 5'd5; v.fp_we = 1; v.opa = 64'hFFFFFFFF_3F800000;
    v.opb = 64'hFFFFFFFF_40000000; v.res = 64'h00000000_40400000;
    v.e_kind = 1; v.e_data = 64'hFFFFFFFF_40400000; v.e_fflags_we = 1; v.e_nvalid = 1; v.e_hs = 1; v.e_idle = 4;
    tbl.push_back(v);
    // dynamic rm, frm=5 reserved
    v = blank(); v.op = 4'd2; v.dyn = 1; v.frm = 3'd5; v.rd = 5'd3; v.fp_we = 1; v.e_rm = 3'd5;
    v.e_illegal = 1; v.e_idle = 2;
    tbl.push_back(v);
    // dynamic rm, frm=7 reserved
    v = blank(); v.op = 4'd3; v.dyn = 1; v.frm = 3'd7; v.rd = 5'd2; v.e_rm = 3'd7; v.e_illegal = 1; v.e_idle = 2;
    tbl.push_back(v);
    // FMUL.D with ready stalled 4 cycles
    v = blank(); v.op = 4'd3; v.rm = 3'd1; v.src = 3'd1; v.dst = 3'd1; v.rd = 5'd7; v.fp_we = 1;
    v.opa = 64'h400921FB_54442D18; v.opb = 64'h40000000_00000000; v.opc = 64'h1234;
    v.res = 64'h401921FB_54442D18; v.status = 5'b00001; v.in_dly = 4; v.out_dly = 1;
    v.e_rm = 3'd1; v.e_kind = 1; v.e_data = 64'h401921FB_54442D18; v.e_fflags_we = 1; v.e_fflags = 5'b00001;
    v.e_nvalid = 5; v.e_hs = 1; v.e_idle = 9;
    tbl.push_back(v);
    // FEQ.D to integer regfile, NV set
    v = blank(); v.op = 4'd8; v.rm = 3'd2; v.src = 3'd1; v.dst = 3'd1; v.rd = 5'd10;
    v.opa = 64'h7FF40000_00000000; v.res = 64'h1; v.status = 5'b10000; v.out_dly = 2;
    v.e_rm = 3'd2; v.e_kind = 2; v.e_data = 64'h1; v.e_fflags_we = 1; v.e_fflags = 5'b10000;
    v.e_nvalid = 1; v.e_hs = 1; v.e_idle = 6;
    tbl.push_back(v);
    // flush while waiting for the result
    v = blank(); v.op = 4'd4; v.rd = 5'd12; v.fp_we = 1; v.res = 64'h3F00_0000; v.status = 5'b01000;
    v.out_dly = 2; v.flush_mode = 3; v.e_nvalid = 1; v.e_hs = 1; v.e_idle = 6;
    tbl.push_back(v);
    // FMV.W.X
    v = blank(); v.op = 4'd6; v.mv = 1; v.fp_we = 1; v.rd = 5'd8; v.opa = 64'h00000000_DEADBEEF;
    v.status = 5'b11111; v.e_kind = 1; v.e_data = 64'hFFFFFFFF_DEADBEEF; v.e_idle = 2;
    tbl.push_back(v);
    // FMV.X.W
    v = blank(); v.op = 4'd6; v.mv = 1; v.rd = 5'd9; v.opa = 64'hFFFFFFFF_12345678;
    v.e_kind = 2; v.e_data = 64'h12345678; v.e_idle = 2;
    tbl.push_back(v);
    // dynamic rm with frm=3 and frm=4 (largest legal) resolved from frm
    v = blank(); v.op = 4'd2; v.dyn = 1; v.frm = 3'd3; v.rm = 3'd7; v.src = 3'd1; v.dst = 3'd1; v.rd = 5'd1;
    v.fp_we = 1; v.res = 64'h3FF00000_00000000; v.in_dly = 1; v.e_rm = 3'd3; v.e_kind = 1;
    v.e_data = 64'h3FF00000_00000000; v.e_fflags_we = 1; v.e_nvalid = 2; v.e_hs = 1; v.e_idle = 5;
    tbl.push_back(v);
    v = blank(); v.op = 4'd0; v.dyn = 1; v.frm = 3'd4; v.dst = 3'd1; v.src = 3'd1; v.rd = 5'd30;
    v.fp_we = 1; v.res = 64'hC000_0000_0000_0001; v.e_rm = 3'd4; v.e_kind = 1;
    v.e_data = 64'hC000_0000_0000_0001; v.e_fflags_we = 1; v.e_nvalid = 1; v.e_hs = 1; v.e_idle = 4;
    tbl.push_back(v);
    // flush in ISSUE without ready: nothing issued
    v = blank(); v.op = 4'd2; v.rd = 5'd6; v.fp_we = 1; v.in_dly = 3; v.flush_mode = 1; v.e_nvalid = 1; v.e_idle = 2;
    tbl.push_back(v);
    // flush on the issue handshake: result drained, no write
    v = blank(); v.op = 4'd5; v.rd = 5'd6; v.fp_we = 1; v.in_dly = 2; v.out_dly = 1; v.flush_mode = 2;
    v.e_nvalid = 3; v.e_hs = 1; v.e_idle = 7;
    tbl.push_back(v);
    // flush during WB suppresses writes
    v = blank(); v.op = 4'd2; v.op_mod = 1; v.rd = 5'd31; v.fp_we = 1; v.res = 64'h40400000; v.flush_mode = 4;
    v.e_nvalid = 1; v.e_hs = 1; v.e_idle = 4;
    tbl.push_back(v);
    // FCVT.W.D to integer regfile
    v = blank(); v.op = 4'd11; v.src = 3'd1; v.rd = 5'd4; v.res = 64'hFFFFFFFF_FFFFFFF6; v.status = 5'b00001;
    v.e_kind = 2; v.e_data = 64'h00000000_FFFFFFF6; v.e_fflags_we = 1; v.e_fflags = 5'b00001;
    v.e_nvalid = 1; v.e_hs = 1; v.e_idle = 4;
    tbl.push_back(v);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 200; i++) begin
      v = blank();
      v.op = 4'($urandom_range(0, 13)); v.op_mod = 1'($urandom_range(0, 1));
      v.rm = 3'($urandom_range(0, 4)); v.dyn = 1'($urandom_range(0, 1)); v.frm = 3'($urandom_range(0, 7));
      v.src = 3'($urandom_range(0, 1)); v.dst = 3'($urandom_range(0, 1)); v.rd = 5'($urandom_range(0, 31));
      v.fp_we = 1'($urandom_range(0, 1)); v.mv = ($urandom_range(0, 4) == 0);
      v.opa = {$urandom, $urandom}; v.opb = {$urandom, $urandom}; v.opc = {$urandom, $urandom};
      v.res = {$urandom, $urandom}; v.status = 5'($urandom_range(0, 31));
      v.in_dly = $urandom_range(0, 3); v.out_dly = $urandom_range(0, 3);
      v.flush_mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      if (v.mv && v.flush_mode >= 1 && v.flush_mode <= 3) v.flush_mode = 0;
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    // reset while ISSUE is stalled
    v = tbl[0];
    @(negedge clk_i); idle_inputs(); drive_dec(v); dec_valid_i = 1'b1;
    @(negedge clk_i); dec_valid_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; #1;
    check("rst_issue ready", {dec_ready_o, fpu_in_valid_o}, 2'b10);
    expect_quiet("rst_issue", 3);

    // reset while WAITing; a late result must be ignored
    @(negedge clk_i); idle_inputs(); dec_valid_i = 1'b1;
    @(negedge clk_i); dec_valid_i = 1'b0; fpu_in_ready_i = 1'b1;
    @(negedge clk_i); fpu_in_ready_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0; fpu_out_valid_i = 1'b1; #1;
    check("rst_wait out_ready", fpu_out_ready_o, 0);
    expect_quiet("rst_wait", 3);
    fpu_out_valid_i = 1'b0;

    // reset coinciding with an accept of a bad-rm op: no ERR pulse
    v = tbl[1];
    @(negedge clk_i); idle_inputs(); drive_dec(v); dec_valid_i = 1'b1; rst_i = 1'b1;
    @(negedge clk_i); dec_valid_i = 1'b0; rst_i = 1'b0;
    expect_quiet("rst_err", 2);

    run_vec(tbl[0], "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
